// File: rtl/code_loader.sv
// ---------------------------------------------------------------------------
// code_loader
//
// Purpose:
//   Assembles 17-bit instruction words from a byte stream and writes them
//   into code memory at consecutive word addresses 0 .. WORDS-1. Three bytes
//   make up one word: byte 0 -> word[7:0], byte 1 -> word[15:8], and bit 0
//   of byte 2 -> word[16]. Bits [7:1] of byte 2 are reserved. If any of them
//   is set, the sticky error flag is raised, but the word is still written.
//   The CPU is held stalled from the start of a session until a complete
//   image has been loaded.
//
// Optional feature (macro CODE_LOADER_CHECKSUM_EN):
//   When this macro is defined, the loader keeps an 8-bit running sum of all
//   accepted image bytes. After the last word it accepts one checksum byte.
//   A match completes the load. A mismatch ends the session with err set,
//   no done pulse and the CPU still halted. The default build leaves the
//   macro undefined and goes straight from the last write to FIN.
//
// Parameters:
//   WORDS   number of 17-bit words per image (WORDS <= 2**ADDR_W)
//   ADDR_W  code-memory word-address width
//
// Ports:
//   Clock       in   rising-edge clock
//   Reset_n     in   synchronous active-low reset; clears state and outputs
//   start       in   starts a session when sampled high in IDLE
//   abort       in   ends an active session with err set (highest priority)
//   byte_valid  in   byte_data carries a byte
//   byte_data   in   8-bit image byte
//   byte_ready  out  the loader accepts a byte this cycle
//   wr_en       out  code-memory write strobe (one cycle per word)
//   wr_addr     out  code-memory word address
//   wr_data     out  17-bit instruction word
//   cpu_halt    out  CPU stall while the image is incomplete
//   busy        out  a session is active (state is not IDLE)
//   done        out  one-cycle pulse on successful completion
//   err         out  sticky error flag, cleared when a new session starts
// ---------------------------------------------------------------------------
module code_loader #(
    parameter int WORDS  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [16:0]       wr_data,
    output logic              cpu_halt,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] B0    = 3'd1;
    localparam logic [2:0] B1    = 3'd2;
    localparam logic [2:0] B2    = 3'd3;
    localparam logic [2:0] WRITE = 3'd4;
    localparam logic [2:0] FIN   = 3'd5;
`ifdef CODE_LOADER_CHECKSUM_EN
    localparam logic [2:0] CHK   = 3'd6;
`endif

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic       abort_hit;
    logic       take_byte;
    logic       last_word;
    logic       rsvd_set;
`ifdef CODE_LOADER_CHECKSUM_EN
    logic [7:0] sum;
    logic       sum_ok;
`endif

    // An abort in IDLE has no session to end, so it is ignored there.
    assign abort_hit = abort && (state != IDLE);
    assign last_word = (wr_addr == LAST_ADDR);
    assign rsvd_set  = |byte_data[7:1];

    // A byte offered in an abort cycle is not consumed, because abort wins.
    assign take_byte = byte_valid && byte_ready && !abort_hit;

`ifdef CODE_LOADER_CHECKSUM_EN
    assign sum_ok     = (byte_data == sum);
    assign byte_ready = (state == B0) || (state == B1) || (state == B2) ||
                        (state == CHK);
`else
    assign byte_ready = (state == B0) || (state == B1) || (state == B2);
`endif

    // The strobes are gated by abort so an aborted WRITE or FIN cycle
    // produces neither a memory write nor a completion pulse.
    assign wr_en = (state == WRITE) && !abort_hit;
    assign done  = (state == FIN) && !abort_hit;
    assign busy  = (state != IDLE);

    // Next-state selection.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) state_nxt = B0;
            end
            B0: begin
                if (take_byte) state_nxt = B1;
            end
            B1: begin
                if (take_byte) state_nxt = B2;
            end
            B2: begin
                if (take_byte) state_nxt = WRITE;
            end
            WRITE: begin
                if (last_word) begin
`ifdef CODE_LOADER_CHECKSUM_EN
                    state_nxt = CHK;
`else
                    state_nxt = FIN;
`endif
                end else begin
                    state_nxt = B0;
                end
            end
`ifdef CODE_LOADER_CHECKSUM_EN
            CHK: begin
                if (take_byte) state_nxt = sum_ok ? FIN : IDLE;
            end
`endif
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (abort_hit) state_nxt = IDLE;
    end

    // State and datapath registers.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state    <= IDLE;
            wr_addr  <= '0;
            wr_data  <= '0;
            cpu_halt <= 1'b0;
            err      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (abort_hit) begin
                // The image is incomplete, so the CPU stays stalled.
                err      <= 1'b1;
                cpu_halt <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            wr_addr  <= '0;
                            err      <= 1'b0;
                            cpu_halt <= 1'b1;
                        end
                    end
                    B0: begin
                        if (take_byte) wr_data[7:0] <= byte_data;
                    end
                    B1: begin
                        if (take_byte) wr_data[15:8] <= byte_data;
                    end
                    B2: begin
                        if (take_byte) begin
                            wr_data[16] <= byte_data[0];
                            if (rsvd_set) err <= 1'b1;
                        end
                    end
                    WRITE: begin
                        // The address holds at the last word and never wraps.
                        if (last_word) begin
`ifndef CODE_LOADER_CHECKSUM_EN
                            // Release the CPU at the transition into FIN so it
                            // is already low while done is high.
                            cpu_halt <= 1'b0;
`endif
                        end else begin
                            wr_addr <= wr_addr + ADDR_W'(1);
                        end
                    end
`ifdef CODE_LOADER_CHECKSUM_EN
                    CHK: begin
                        if (take_byte) begin
                            if (sum_ok) cpu_halt <= 1'b0;
                            else        err      <= 1'b1;
                        end
                    end
`endif
                    default: begin
                    end
                endcase
            end
        end
    end

`ifdef CODE_LOADER_CHECKSUM_EN
    // Running sum (mod 256) of the image bytes of the current session.
    // The checksum byte itself is not included.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            sum <= '0;
        end else if ((state == IDLE) && start) begin
            sum <= '0;
        end else if (take_byte && (state != CHK)) begin
            sum <= sum + byte_data;
        end
    end
`endif

endmodule

// File: tb/tb_code_loader.sv
// ---------------------------------------------------------------------------
// tb_code_loader
//
// Purpose:
//   Directed bench for code_loader. Image bytes are random. Expected writes,
//   error flag and checksum come from a byte-array image model. A negedge
//   monitor records every memory write and every done pulse.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_code_loader;

    localparam int WORDS  = 32;
    localparam int ADDR_W = 5;

    logic              Clock = 1'b0;
    logic              Reset_n;
    logic              start;
    logic              abort;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [16:0]       wr_data;
    logic              cpu_halt;
    logic              busy;
    logic              done;
    logic              err;

    always #5 Clock = ~Clock;

    code_loader #(
        .WORDS (WORDS),
        .ADDR_W(ADDR_W)
    ) dut (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .start     (start),
        .abort     (abort),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .byte_ready(byte_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .cpu_halt  (cpu_halt),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] wr_q[$];
    int          done_cnt = 0;
    int          halt_bad = 0;
    logic [7:0]  b0[WORDS];
    logic [7:0]  b1[WORDS];
    logic [7:0]  b2[WORDS];

    // Monitor: each write is packed as {addr, data}, with data in bits [16:0].
    always @(negedge Clock) begin
        if (wr_en) wr_q.push_back((32'(wr_addr) << 17) | 32'(wr_data));
        if (done) begin
            done_cnt++;
            if (cpu_halt) halt_bad++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Image model.
    function automatic logic [31:0] model_word(input int i);
        return 32'({b2[i][0], b1[i], b0[i]});
    endfunction

    function automatic logic [31:0] model_err();
        logic e;
        e = 1'b0;
        for (int i = 0; i < WORDS; i++) if (b2[i][7:1] != 7'd0) e = 1'b1;
        return 32'(e);
    endfunction

    function automatic logic [7:0] model_sum();
        int s;
        s = 0;
        for (int i = 0; i < WORDS; i++) s += int'(b0[i]) + int'(b1[i]) + int'(b2[i]);
        return 8'(s);
    endfunction

    task automatic fill_image(input int rsvd_word);
        for (int i = 0; i < WORDS; i++) begin
            b0[i] = 8'($urandom_range(0, 255));
            b1[i] = 8'($urandom_range(0, 255));
            b2[i] = 8'($urandom_range(0, 1));
            if (i == rsvd_word) b2[i] = 8'h03;
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 just after the byte is taken.
    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n;
        n = 0;
        byte_data  = b;
        byte_valid = 1'b1;
        while (!byte_ready && n < 20) begin
            tick();
            n++;
        end
        if (!byte_ready) begin
            n_cmp++;
            n_bad++;
            $error("FAIL byte_timeout: byte_ready observed 0 expected 1");
        end
        tick();
        byte_valid = 1'b0;
        if (gap) tick();
    endtask

    task automatic send_words(input int first, input int last, input int gap_mode);
        bit g;
        for (int i = first; i <= last; i++) begin
            g = (gap_mode == 1) || (gap_mode == 2 && $urandom_range(0, 1) == 1);
            send_byte(b0[i], g);
            send_byte(b1[i], g);
            send_byte(b2[i], g);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic check_writes(input string tag, input int base, input int nwords);
        check({tag, "_count"}, 32'(wr_q.size() - base), 32'(nwords));
        for (int i = 0; i < nwords && base + i < wr_q.size(); i++)
            check($sformatf("%s_w%0d", tag, i), wr_q[base + i], (32'(i) << 17) | model_word(i));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
        check({tag, "_wr_en"},      32'(wr_en),      32'd0);
        check({tag, "_wr_addr"},    32'(wr_addr),    32'd0);
        check({tag, "_wr_data"},    32'(wr_data),    32'd0);
        check({tag, "_cpu_halt"},   32'(cpu_halt),   32'd0);
        check({tag, "_busy"},       32'(busy),       32'd0);
        check({tag, "_done"},       32'(done),       32'd0);
        check({tag, "_err"},        32'(err),        32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wbase;
        int dbase;

        Reset_n    = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        tick();
        tick();
        check_zero("reset");

        // First-word write, then a full load with byte_valid toggling.
        fill_image(-1);
        b0[0] = 8'h00; b1[0] = 8'h30; b2[0] = 8'h00;
        b0[1] = 8'h08; b1[1] = 8'h8C; b2[1] = 8'h00;
        wbase = wr_q.size();
        dbase = done_cnt;
        Reset_n = 1'b1;
        start   = 1'b1;
        tick();
        start = 1'b0;
        send_words(0, 0, 0);
        check("s1_wr_en",    32'(wr_en),    32'd1);
        check("s1_wr_addr",  32'(wr_addr),  32'd0);
        check("s1_wr_data",  32'(wr_data),  32'h03000);
        check("s1_busy",     32'(busy),     32'd1);
        check("s1_cpu_halt", 32'(cpu_halt), 32'd1);
        send_words(1, WORDS - 1, 1);
`ifdef CODE_LOADER_CHECKSUM_EN
        send_byte(model_sum(), 1'b0);
`endif
        wait_idle("s1_idle");
        check_writes("s1", wbase, WORDS);
        check("s1_done_cnt", 32'(done_cnt - dbase), 32'd1);
        check("s1_err",      32'(err),      model_err());
        check("s1_halt_end", 32'(cpu_halt), 32'd0);

        // Reserved bits set in byte 2 of word 5.
        fill_image(5);
        wbase = wr_q.size();
        dbase = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        send_words(0, 4, 2);
        check("s2_err_before", 32'(err), 32'd0);
        send_words(5, 5, 0);
        check("s2_w5_wr_en",  32'(wr_en),       32'd1);
        check("s2_w5_bit16",  32'(wr_data[16]), 32'd1);
        check("s2_err_after", 32'(err),         32'd1);
        send_words(6, WORDS - 1, 2);
`ifdef CODE_LOADER_CHECKSUM_EN
        send_byte(model_sum(), 1'b0);
`endif
        wait_idle("s2_idle");
        check_writes("s2", wbase, WORDS);
        check("s2_done_cnt", 32'(done_cnt - dbase), 32'd1);
        check("s2_err_end",  32'(err),      model_err());
        check("s2_halt_end", 32'(cpu_halt), 32'd0);

        // Abort after byte 1 of word 7, with a byte offered in the same cycle.
        fill_image(-1);
        wbase = wr_q.size();
        dbase = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        send_words(0, 6, 2);
        send_byte(b0[7], 1'b0);
        send_byte(b1[7], 1'b0);
        abort      = 1'b1;
        byte_valid = 1'b1;
        byte_data  = b2[7];
        tick();
        abort      = 1'b0;
        byte_valid = 1'b0;
        check("s3_busy",     32'(busy),     32'd0);
        check("s3_err",      32'(err),      32'd1);
        check("s3_cpu_halt", 32'(cpu_halt), 32'd1);
        check("s3_done",     32'(done),     32'd0);
        tick();
        tick();
        tick();
        check_writes("s3", wbase, 7);
        check("s3_done_cnt", 32'(done_cnt - dbase), 32'd0);
        check("s3_halt_end", 32'(cpu_halt), 32'd1);

`ifdef CODE_LOADER_CHECKSUM_EN
        // Wrong checksum byte (sum + 1).
        fill_image(-1);
        wbase = wr_q.size();
        dbase = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        send_words(0, WORDS - 1, 2);
        send_byte(model_sum() + 8'd1, 1'b0);
        wait_idle("s4_idle");
        check_writes("s4", wbase, WORDS);
        check("s4_done_cnt", 32'(done_cnt - dbase), 32'd0);
        check("s4_err",      32'(err),      32'd1);
        check("s4_cpu_halt", 32'(cpu_halt), 32'd1);
`endif

        // start held high through the session, with reset applied during B1.
        fill_image(-1);
        wbase = wr_q.size();
        start = 1'b1;
        tick();
        send_words(0, 0, 0);
        check("s5_wr_en",    32'(wr_en),   32'd1);
        check("s5_wr_addr0", 32'(wr_addr), 32'd0);
        send_byte(b0[1], 1'b0);
        check("s5_busy",     32'(busy),    32'd1);
        check("s5_wr_addr1", 32'(wr_addr), 32'd1);
        Reset_n    = 1'b0;
        byte_valid = 1'b1;
        byte_data  = b1[1];
        tick();
        byte_valid = 1'b0;
        check_zero("s5_reset");
        start = 1'b0;
        tick();
        Reset_n = 1'b1;
        tick();
        tick();
        tick();
        check("s5_writes", 32'(wr_q.size() - wbase), 32'd1);
        check("s5_idle",   32'(busy), 32'd0);
        check("halt_in_fin", 32'(halt_bad), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
